// File: rtl/edge_cache.sv
// Single-row adjacency cache: fetches one matrix row into a local buffer and
// serves (from,to) edge queries from it, including partially filled rows.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif

module edge_cache #(
  parameter int unsigned MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int unsigned INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int unsigned VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  base_address,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic                   invalidate,
  input  logic                   ec_query,
  input  logic [INDEX_WIDTH-1:0] ec_from_node,
  input  logic [INDEX_WIDTH-1:0] ec_to_node,
  output logic                   ec_ready,
  output logic [VALUE_WIDTH-1:0] ec_edge_value,
  output logic                   mem_read,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  input  logic                   mem_waitrequest,
  input  logic                   mem_readdatavalid,
  input  logic [VALUE_WIDTH-1:0] mem_readdata,
  output logic                   busy
);

  localparam int unsigned CNT_W  = $clog2(MAX_NODES + 1);
  localparam int unsigned BUF_AW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam int unsigned CMP_W  = (INDEX_WIDTH > CNT_W) ? INDEX_WIDTH : CNT_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] row_tag_q, row_tag_d;
  logic                   row_valid_q, row_valid_d;
  logic [CNT_W-1:0]       fill_count_q, fill_count_d;
  logic [CNT_W-1:0]       n_latched_q, n_latched_d;
  logic [VALUE_WIDTH-1:0] buffer_q [MAX_NODES];
  logic                   buf_we;

  logic             tag_hit;
  logic             miss;
  logic             abort;
  logic [CNT_W-1:0] n_clamped;
  logic [CNT_W-1:0] fill_next;

  assign tag_hit   = row_valid_q && (row_tag_q == ec_from_node);
  assign miss      = ec_query && !tag_hit;
  assign abort     = miss || invalidate;
  assign fill_next = fill_count_q + CNT_W'(1);
  assign n_clamped = (CMP_W'(number_of_nodes) > CMP_W'(MAX_NODES)) ?
                     CNT_W'(MAX_NODES) : CNT_W'(number_of_nodes);

  // Only entries already written are served; anything past the fill point reads as not ready.
  assign ec_ready      = ec_query && tag_hit && (CMP_W'(ec_to_node) < CMP_W'(fill_count_q));
  assign ec_edge_value = ec_ready ? buffer_q[BUF_AW'(ec_to_node)] : '0;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    row_tag_d    = row_tag_q;
    row_valid_d  = row_valid_q;
    fill_count_d = fill_count_q;
    n_latched_d  = n_latched_q;
    buf_we       = 1'b0;
    mem_read     = 1'b0;
    mem_address  = '0;

    if (invalidate) row_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!invalidate && miss) begin
          row_tag_d    = ec_from_node;
          row_valid_d  = 1'b1;
          fill_count_d = '0;
          n_latched_d  = n_clamped;
          if (n_clamped != '0) state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Request is withdrawn before acceptance; IDLE restarts if a miss is still present.
        if (abort) begin
          state_d = IDLE;
        end else begin
          mem_read    = 1'b1;
          mem_address = base_address
                      + ADDR_WIDTH'(row_tag_q) * ADDR_WIDTH'(n_latched_q)
                      + ADDR_WIDTH'(fill_count_q);
          if (!mem_waitrequest) state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (mem_readdatavalid) begin
          buf_we       = 1'b1;
          fill_count_d = fill_next;
          state_d      = (!abort && (fill_next < n_latched_q)) ? ISSUE : IDLE;
        end else if (abort) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_readdatavalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      row_tag_q    <= '0;
      row_valid_q  <= 1'b0;
      fill_count_q <= '0;
      n_latched_q  <= '0;
    end else begin
      state_q      <= state_d;
      row_tag_q    <= row_tag_d;
      row_valid_q  <= row_valid_d;
      fill_count_q <= fill_count_d;
      n_latched_q  <= n_latched_d;
    end
  end

  // Row storage is deliberately left unreset; validity is tracked by the tags.
  always_ff @(posedge clock) begin
    if (buf_we) buffer_q[BUF_AW'(fill_count_q)] <= mem_readdata;
  end

endmodule

// File: tb/tb_edge_cache.sv
// Directed bench for edge_cache: a small read-latency memory model plus
// hand-computed expectations (memory word at address a holds 0x1000 + a).
module tb_edge_cache;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] base_address;
  logic [7:0]  number_of_nodes;
  logic        invalidate;
  logic        ec_query;
  logic [7:0]  ec_from_node;
  logic [7:0]  ec_to_node;
  logic        ec_ready;
  logic [15:0] ec_edge_value;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        mem_waitrequest;
  logic        mem_readdatavalid = 1'b0;
  logic [15:0] mem_readdata = 16'h0;
  logic        busy;

  int errors = 0;
  int checks = 0;

  int          lat = 1;
  int          pend_cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          read_count = 0;
  logic [31:0] addr_log [$];

  edge_cache dut (
    .clock(clock), .reset(reset), .base_address(base_address),
    .number_of_nodes(number_of_nodes), .invalidate(invalidate),
    .ec_query(ec_query), .ec_from_node(ec_from_node), .ec_to_node(ec_to_node),
    .ec_ready(ec_ready), .ec_edge_value(ec_edge_value),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
    .mem_readdata(mem_readdata), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return 16'(32'h1000 + a);
  endfunction

  // Memory responder: one read in flight, response `lat` cycles after acceptance.
  always @(posedge clock) begin
    mem_readdatavalid <= 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        mem_readdatavalid <= 1'b1;
        mem_readdata      <= mem_word(pend_addr);
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (mem_read === 1'b1 && mem_waitrequest === 1'b0) begin
      read_count++;
      addr_log.push_back(mem_address);
      if (lat <= 1) begin
        mem_readdatavalid <= 1'b1;
        mem_readdata      <= mem_word(mem_address);
      end else begin
        pend      = 1'b1;
        pend_cnt  = lat - 1;
        pend_addr = mem_address;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < budget) begin
      tick();
      i++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    logic bad;
    reset           = 1'b1;
    base_address    = 32'd100;
    number_of_nodes = 8'd4;
    invalidate      = 1'b0;
    ec_query        = 1'b0;
    ec_from_node    = 8'd0;
    ec_to_node      = 8'd0;
    mem_waitrequest = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_ec_ready", 32'(ec_ready), 32'd0);

    // Row 2 fill, zero-wait memory, 1-cycle latency: reads at 108..111.
    reset = 1'b0;
    ec_query = 1'b1;
    ec_from_node = 8'd2;
    tick();
    chk("fill_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      ec_to_node = 8'(k);
      chk("fill_mem_read", 32'(mem_read), 32'd1);
      chk("fill_addr", mem_address, 32'(108 + k));
      tick();
      chk("fill_rdv", 32'(mem_readdatavalid), 32'd1);
      chk("fill_not_ready_yet", 32'(ec_ready), 32'd0);
      tick();
      chk("fill_ready", 32'(ec_ready), 32'd1);
      chk("fill_value", 32'(ec_edge_value), 32'(16'h106C + k));
    end
    chk("fill_done_busy", 32'(busy), 32'd0);
    chk("fill_reads", 32'(read_count), 32'd4);

    // Cached row: immediate hits, no traffic.
    for (int k = 0; k < 4; k++) begin
      ec_to_node = 8'(k);
      #1;
      chk("hit_ready", 32'(ec_ready), 32'd1);
      chk("hit_value", 32'(ec_edge_value), 32'(16'h106C + k));
      tick();
      chk("hit_mem_read", 32'(mem_read), 32'd0);
    end
    chk("hit_reads", 32'(read_count), 32'd4);

    // Column equal to node count is never ready and never fetches.
    ec_to_node = 8'd4;
    #1;
    chk("to_eq_n_ready", 32'(ec_ready), 32'd0);
    tick(); tick(); tick();
    chk("to_eq_n_ready_later", 32'(ec_ready), 32'd0);
    chk("to_eq_n_busy", 32'(busy), 32'd0);
    chk("to_eq_n_reads", 32'(read_count), 32'd4);

    // Invalidate then refetch the same row.
    ec_to_node = 8'd0;
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    chk("inv_ready", 32'(ec_ready), 32'd0);
    tick();
    chk("inv_refetch_busy", 32'(busy), 32'd1);
    wait_idle("inv_idle", 40);
    chk("inv_reads", 32'(read_count), 32'd8);
    ec_to_node = 8'd3;
    #1;
    chk("inv_value", 32'(ec_edge_value), 32'h106F);

    // Waitrequest held for three ISSUE cycles on row 1 (104..107).
    ec_from_node = 8'd1;
    ec_to_node = 8'd0;
    mem_waitrequest = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("wait_mem_read", 32'(mem_read), 32'd1);
      chk("wait_addr", mem_address, 32'd104);
    end
    chk("wait_reads", 32'(read_count), 32'd8);
    mem_waitrequest = 1'b0;
    wait_idle("wait_idle", 40);
    chk("wait_reads_done", 32'(read_count), 32'd12);
    ec_to_node = 8'd2;
    #1;
    chk("wait_value", 32'(ec_edge_value), 32'h106A);

    // Source switches 2 -> 5 while a row-2 response is outstanding.
    lat = 3;
    ec_from_node = 8'd2;
    ec_to_node = 8'd0;
    tick();
    chk("sw_addr", mem_address, 32'd108);
    tick();
    ec_from_node = 8'd5;
    ec_to_node = 8'd1;
    bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (ec_ready === 1'b1 && (ec_edge_value < 16'h1078 || ec_edge_value > 16'h107B)) bad = 1'b1;
    end
    chk("sw_no_stale", 32'(bad), 32'd0);
    chk("sw_busy", 32'(busy), 32'd0);
    chk("sw_reads", 32'(read_count), 32'd17);
    chk("sw_first_new_addr", addr_log[13], 32'd120);
    chk("sw_last_addr", addr_log[16], 32'd123);
    chk("sw_ready", 32'(ec_ready), 32'd1);
    chk("sw_value", 32'(ec_edge_value), 32'h1079);

    // Reset in WAIT_DATA; the late response must be ignored.
    ec_from_node = 8'd7;
    ec_to_node = 8'd0;
    tick();
    chk("rmid_addr", mem_address, 32'd128);
    tick();
    reset = 1'b1;
    tick();
    chk("rmid_mem_read", 32'(mem_read), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_addr0", mem_address, 32'd0);
    reset = 1'b0;
    ec_query = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("rmid_late_busy", 32'(busy), 32'd0);
    chk("rmid_reads", 32'(read_count), 32'd18);

    // Zero-node graph: query misses but never reads memory.
    lat = 1;
    number_of_nodes = 8'd0;
    ec_query = 1'b1;
    #1;
    chk("n0_ready", 32'(ec_ready), 32'd0);
    for (int c = 0; c < 4; c++) tick();
    chk("n0_busy", 32'(busy), 32'd0);
    chk("n0_reads", 32'(read_count), 32'd18);
    chk("n0_ready_later", 32'(ec_ready), 32'd0);

    // Node count above the buffer depth clamps to 16: row 1 at 116..131.
    number_of_nodes = 8'd20;
    ec_from_node = 8'd1;
    ec_to_node = 8'd0;
    tick();
    chk("clamp_addr", mem_address, 32'd116);
    wait_idle("clamp_idle", 100);
    chk("clamp_reads", 32'(read_count), 32'd34);
    chk("clamp_last_addr", addr_log[33], 32'd131);
    ec_to_node = 8'd15;
    #1;
    chk("clamp_ready_15", 32'(ec_ready), 32'd1);
    chk("clamp_value_15", 32'(ec_edge_value), 32'h1083);
    ec_to_node = 8'd16;
    #1;
    chk("clamp_ready_16", 32'(ec_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
